// File: rtl/pcie_tx_mwr_if.sv
// rtl/pcie_tx_mwr_if.sv - request, payload FIFO and TX stream bundle of the MWr TLP builder
interface pcie_tx_mwr_if;
  logic        req_valid;
  logic        req_ready;
  logic [60:0] req_addr;
  logic [4:0]  req_len;
  logic [63:0] data_in;
  logic [5:0]  data_level;
  logic        data_ready;
  logic        s_axis_tx_tready;
  logic [63:0] s_axis_tx_tdata;
  logic        s_axis_tx_1dw;
  logic        s_axis_tx_tlast;
  logic        s_axis_tx_tvalid;

  modport master (
    output req_valid, req_addr, req_len, data_in, data_level, s_axis_tx_tready,
    input  req_ready, data_ready, s_axis_tx_tdata, s_axis_tx_1dw, s_axis_tx_tlast, s_axis_tx_tvalid
  );

  modport slave (
    input  req_valid, req_addr, req_len, data_in, data_level, s_axis_tx_tready,
    output req_ready, data_ready, s_axis_tx_tdata, s_axis_tx_1dw, s_axis_tx_tlast, s_axis_tx_tvalid
  );
endinterface

// File: rtl/pcie_tx_mwr.sv
// rtl/pcie_tx_mwr.sv - PCIe memory-write TLP builder streaming qwords from an FWFT FIFO
// ADDR64_EN enables 4DW headers for requests above 4 GiB; otherwise every TLP is 3DW.
module pcie_tx_mwr (
  input  logic         clock,
  input  logic         rst_n,
  input  logic [15:0]  pci_id,
  pcie_tx_mwr_if.slave bus,
  output logic         busy,
  output logic         err_len,
  output logic [15:0]  tlp_count
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, TAIL} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [28:0] addr_lo_q;
  logic [4:0]  len_q;
  logic [15:0] id_q;
  logic [4:0]  remaining;
  logic [31:0] prev_hi;
  logic [2:0]  fmt;
  logic        len_bad;
  logic        accept;
  logic        pop;
  logic        done;

`ifdef ADDR64_EN
  logic [31:0] addr_hi_q;
  logic        is4dw_q;
  assign fmt = is4dw_q ? 3'b011 : 3'b010;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[60:29];
  assign fmt = 3'b010;
`endif

  assign len_bad        = (bus.req_len == 5'd0) || (bus.req_len > 5'd16);
  assign busy           = (state != IDLE);
  assign bus.data_ready = pop;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Beat contents are combinational on state and latched fields; the FIFO head
  // only moves on a pop, so a stalled beat holds without extra registers.
  always_comb begin
    state_nxt            = state;
    accept               = 1'b0;
    pop                  = 1'b0;
    done                 = 1'b0;
    bus.req_ready        = 1'b0;
    err_len              = 1'b0;
    bus.s_axis_tx_tvalid = 1'b0;
    bus.s_axis_tx_tlast  = 1'b0;
    bus.s_axis_tx_1dw    = 1'b0;
    bus.s_axis_tx_tdata  = 64'h0;
    case (state)
      IDLE: begin
        if (rst_n && bus.req_valid) begin
          if (len_bad) begin
            bus.req_ready = 1'b1;
            err_len       = 1'b1;
          end else if (bus.data_level >= {1'b0, bus.req_len}) begin
            bus.req_ready = 1'b1;
            accept        = 1'b1;
            state_nxt     = HDR0;
          end
        end
      end
      HDR0: begin
        bus.s_axis_tx_tvalid = 1'b1;
        bus.s_axis_tx_tdata  = {id_q, 8'h00, 4'hF, 4'hF, fmt, 19'h0, 4'h0, len_q, 1'b0};
        if (bus.s_axis_tx_tready) begin
          state_nxt = HDR1;
        end
      end
      HDR1: begin
        bus.s_axis_tx_tvalid = 1'b1;
`ifdef ADDR64_EN
        if (is4dw_q) begin
          bus.s_axis_tx_tdata = {addr_lo_q, 3'b000, addr_hi_q};
          if (bus.s_axis_tx_tready) begin
            state_nxt = DATA;
          end
        end else
`endif
        begin
          bus.s_axis_tx_tdata = {bus.data_in[31:0], addr_lo_q, 3'b000};
          if (bus.s_axis_tx_tready) begin
            pop       = 1'b1;
            state_nxt = (remaining == 5'd1) ? TAIL : DATA;
          end
        end
      end
      DATA: begin
        bus.s_axis_tx_tvalid = 1'b1;
`ifdef ADDR64_EN
        if (is4dw_q) begin
          bus.s_axis_tx_tdata = bus.data_in;
          bus.s_axis_tx_tlast = (remaining == 5'd1);
          if (bus.s_axis_tx_tready) begin
            pop = 1'b1;
            if (remaining == 5'd1) begin
              done      = 1'b1;
              state_nxt = IDLE;
            end
          end
        end else
`endif
        begin
          // 3DW header leaves the payload misaligned by one DW: pair the
          // current low DW with the high DW kept from the previous qword.
          bus.s_axis_tx_tdata = {bus.data_in[31:0], prev_hi};
          if (bus.s_axis_tx_tready) begin
            pop = 1'b1;
            if (remaining == 5'd1) begin
              state_nxt = TAIL;
            end
          end
        end
      end
      TAIL: begin
        bus.s_axis_tx_tvalid = 1'b1;
        bus.s_axis_tx_tdata  = {32'h0, prev_hi};
        bus.s_axis_tx_tlast  = 1'b1;
        bus.s_axis_tx_1dw    = 1'b1;
        if (bus.s_axis_tx_tready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      addr_lo_q <= 29'h0;
      len_q     <= 5'h0;
      id_q      <= 16'h0;
      remaining <= 5'h0;
      prev_hi   <= 32'h0;
      tlp_count <= 16'h0;
`ifdef ADDR64_EN
      addr_hi_q <= 32'h0;
      is4dw_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        addr_lo_q <= bus.req_addr[28:0];
        len_q     <= bus.req_len;
        id_q      <= pci_id;
        remaining <= bus.req_len;
`ifdef ADDR64_EN
        addr_hi_q <= bus.req_addr[60:29];
        is4dw_q   <= |bus.req_addr[60:29];
`endif
      end
      if (pop) begin
        remaining <= remaining - 5'd1;
        prev_hi   <= bus.data_in[63:32];
      end
      if (done) begin
        tlp_count <= tlp_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/pcie_tx_mwr.md
PCIE_TX_MWR -- requirements
Module: pcie_tx_mwr

Interface
REQ-001 Clock/reset: one clock `clock`; reset `rst_n`, asynchronous, active-low; all logic in the `clock` domain.
REQ-002 Ports, as name / direction / width / meaning:
- `clock` / in / 1 / core user clock.
- `rst_n` / in / 1 / async active-low reset.
- `pci_id` / in / 16 / requester ID {bus, dev, fn}.
- `req_valid` / in / 1 / write request pending.
- `req_ready` / out / 1 / request accepted this cycle.
- `req_addr` / in / 61 / byte address bits [63:3]; qword aligned.
- `req_len` / in / 5 / payload in qwords; legal range 1..16.
- `data_in` / in / 64 / FWFT FIFO head qword; low DW is sent first.
- `data_level` / in / 6 / qwords available in the FIFO.
- `data_ready` / out / 1 / FIFO pop strobe; the head qword is consumed this cycle.
- `s_axis_tx_tready` / in / 1 / core accepts beat.
- `s_axis_tx_tdata` / out / 64 / TLP beat; first DW in [31:0].
- `s_axis_tx_1dw` / out / 1 / only [31:0] valid.
- `s_axis_tx_tlast` / out / 1 / last beat of TLP.
- `s_axis_tx_tvalid` / out / 1 / beat valid.
- `busy` / out / 1 / state not IDLE.
- `err_len` / out / 1 / one-cycle pulse when an illegal req_len is dropped.
- `tlp_count` / out / 16 / count of completed TLPs.

Function
REQ-003 States SHALL be IDLE, HDR0, HDR1, DATA and TAIL.
- The state SHALL advance only on a beat handshake (tvalid & tready).
- In every other cycle, all s_axis outputs SHALL hold.
REQ-004 In IDLE, when req_valid=1 and req_len=0 or req_len>16, req_ready SHALL pulse for 1 cycle and err_len SHALL pulse for 1 cycle; no TLP is sent.
REQ-005 In IDLE, when req_valid=1, req_len is legal and data_level>=req_len, req_ready SHALL pulse for 1 cycle, the request SHALL be latched, and the next state SHALL be HDR0.
REQ-006 Once HDR0 is entered, tvalid SHALL remain 1 continuously until tlast is accepted; a TLP never contains bubbles.
REQ-007 HDR0 beat:
- [31:0] = DW0: fmt 010 (3DW) or 011 (4DW), type 00000, TC/attr/TD/EP 0, length = 2*req_len DWs.
- [63:32] = DW1: {pci_id, tag 8'h00, lastBE 4'hF, firstBE 4'hF}.
REQ-008 3DW path: HDR1 = {data_in[31:0], addr[31:2],2'b00}.
- Each following DATA beat = {current qword [31:0], previous qword [63:32]}, with the previous high DW held in a 32-bit register.
- TAIL = {32'h0, last qword [63:32]}, with 1dw=1 and tlast=1.
- Total beats = req_len+2.
REQ-009 data_ready SHALL assert exactly on the accepted beats that consume a new qword.
- Exactly req_len pops SHALL occur per TLP.
- A qword is never popped on a stalled beat.
REQ-010 1dw SHALL be 0 on every beat except a 3DW TAIL.
REQ-011 tlp_count SHALL increment on each accepted tlast and wrap from 16'hFFFF to 0.
REQ-012 busy SHALL be 1 in all states except IDLE.
- A new request SHALL NOT be accepted in the cycle in which tlast is accepted.
- The earliest next req_ready SHALL be the following cycle.
REQ-013 req_addr, req_len and pci_id SHALL be sampled only at acceptance; later changes SHALL NOT affect the TLP in flight.

Reset
REQ-014 While rst_n=0:
- state = IDLE.
- req_ready = data_ready = err_len = 0.
- tvalid = tlast = 1dw = 0, tdata = 0.
- tlp_count = 0, busy = 0.
REQ-015 Reset asserted mid-TLP SHALL abandon the partial TLP immediately, with no further pops. After release, the block SHALL start in IDLE.

Configuration
REQ-016 Macro ADDR64_EN:
- When defined, a request with addr[63:32]!=0 SHALL use the 4DW format: fmt 011, HDR1 = {addr[31:2],2'b00, addr[63:32]}, DATA beats carry each qword unshifted, there is no TAIL, the last DATA beat carries tlast with 1dw=0, and total beats = req_len+2.
- When defined, a request with addr[63:32]=0 SHALL use the 3DW format.
- When not defined, req_addr[63:32] SHALL be ignored, every TLP SHALL use the 3DW format, and the 4DW logic SHALL be absent.

Verification
REQ-017 pci_id=16'h0100, addr=32'h1000_0000, len=1, data 64'hBBBB_BBBB_AAAA_AAAA, tready=1 -> 3 beats:
- 64'h0100_00FF_4000_0002
- 64'hAAAA_AAAA_1000_0000
- 64'h0000_0000_BBBB_BBBB with 1dw=1, tlast=1.
REQ-018 len=16, data_level=16, tready toggling 1/0 every cycle -> 18 accepted beats, 16 pops, tvalid never 0 inside the TLP, held beats unchanged while stalled.
REQ-019 len=4, data_level=3 -> no req_ready; data_level rises to 4 -> accept, 6 beats.
REQ-020 req_len=0, then req_len=17 -> 2 err_len pulses, no tvalid, tlp_count unchanged.
REQ-021 rst_n low on beat 3 of a len=8 TLP -> all outputs 0 within the same cycle; after release, len=2 -> clean 4-beat TLP, tlp_count=1.
REQ-022 ADDR64_EN defined, addr=64'h1_0000_0000, len=2 -> DW0 = 32'h6000_0004, HDR1 = 64'h0000_0000_0000_0001, 2 data beats, tlast on beat 4, 1dw=0.
